// File: rtl/serial_sub_4.sv
// Bit-serial ripple-borrow subtractor: diff = a - b - bin, one bit per clock.
// Operands are captured on an accepted start, then shifted LSB-first through
// a single borrow flop; the result appears on the edge that enters DONE.
module serial_sub_4 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);
  localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh, b_sh, work;
  logic             br, a_msb, b_msb;
  logic [IW-1:0]    idx;
  logic             d_bit, br_nx, last;

  // One full-subtractor bit slice on the current LSBs of the shift registers.
  assign d_bit = a_sh[0] ^ b_sh[0] ^ br;
  assign br_nx = (~a_sh[0] & b_sh[0]) | (~a_sh[0] & br) | (b_sh[0] & br);
  assign last  = (idx == IW'(WIDTH-1));

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: DONE accepts start just like IDLE so back-to-back ops have no bubble.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last)  state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: capture, per-bit shift/borrow update, and result publish on the last bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      work  <= '0;
      br    <= 1'b0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      idx   <= '0;
      diff  <= '0;
      bout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            br    <= bin;
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
            idx   <= '0;
          end
        end
        RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          br   <= br_nx;
          work <= {d_bit, work[WIDTH-1:1]};
          idx  <= idx + 1'b1;
          if (last) begin
            // d_bit is the result MSB here; overflow needs only the captured sign bits.
            diff <= {d_bit, work[WIDTH-1:1]};
            bout <= br_nx;
            ovf  <= (a_msb ^ b_msb) & (d_bit ^ a_msb);
          end
        end
        default: ;
      endcase
    end
  end
endmodule
